// File: rtl/forward_pass_host.sv
// ---------------------------------------------------------------------------
// forward_pass_host
//
// Host-side sequencer for a single forward pass through an accelerator.
// A job is a stream of load beats (control code + signed data word) ending
// with a beat flagged s_last. Each beat is replayed to the accelerator one
// cycle after it is accepted. The host then issues a one-cycle start code
// (control 0) and waits for the accelerator's acc_done pulse. NUM_OUTPUTS
// result words are then captured on consecutive cycles and finally streamed
// out on a valid/ready result port together with their index.
//
// Parameters
//   BUS_WIDTH      width of every data word
//   NUM_OUTPUTS    result words captured per job
//   IDLE_CTRL      no-op control code driven when no beat is presented
//   TIMEOUT_CYCLES maximum cycles waited for acc_done
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready       load-stream handshake
//   s_control/s_data      control code and signed data of the load beat
//   s_last                final load beat of the job
//   acc_control/acc_in_bus  beat replay and start code towards accelerator
//   acc_done/acc_out_bus  result-ready pulse and result words from accelerator
//   m_valid/m_ready       result-stream handshake
//   m_data/m_index/m_last result word, its index, final-word marker
//   busy                  high whenever the host is not idle
//   timeout_err           sticky: acc_done never arrived
//   protocol_err          sticky: zero control beat or unexpected acc_done
// ---------------------------------------------------------------------------
module forward_pass_host #(
    parameter int         BUS_WIDTH      = 32,
    parameter int         NUM_OUTPUTS    = 10,
    parameter logic [3:0] IDLE_CTRL      = 4'hF,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [3:0]           s_control,
    input  logic [BUS_WIDTH-1:0] s_data,
    input  logic                 s_last,
    output logic [3:0]           acc_control,
    output logic [BUS_WIDTH-1:0] acc_in_bus,
    input  logic                 acc_done,
    input  logic [BUS_WIDTH-1:0] acc_out_bus,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [BUS_WIDTH-1:0] m_data,
    output logic [3:0]           m_index,
    output logic                 m_last,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 protocol_err
);

    localparam int               IDX_W        = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_OUTPUTS - 1);
    localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic                   s_ready_q, s_ready_d;
    logic [3:0]             acc_control_q, acc_control_d;
    logic [BUS_WIDTH-1:0]   acc_in_bus_q, acc_in_bus_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   m_valid_q, m_valid_d;
    logic [BUS_WIDTH-1:0]   m_data_q, m_data_d;
    logic [3:0]             m_index_q, m_index_d;
    logic                   m_last_q, m_last_d;
    logic                   busy_q, busy_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   protocol_err_q, protocol_err_d;
    logic [BUS_WIDTH-1:0]   res_buf_q [NUM_OUTPUTS];
    logic [BUS_WIDTH-1:0]   res_buf_d [NUM_OUTPUTS];

    logic                   beat_accepted;

    // s_ready is itself a flop, so acceptance never depends combinationally
    // on anything but registered state.
    assign beat_accepted = s_valid && s_ready_q;

    // Next-state and next-output logic. Every registered output is computed
    // here from the next state so the ports come straight from flops.
    always_comb begin
        state_d        = state_q;
        acc_control_d  = IDLE_CTRL;
        acc_in_bus_d   = '0;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        res_buf_d      = res_buf_q;
        timeout_err_d  = timeout_err_q;
        protocol_err_d = protocol_err_q;
        m_valid_d      = 1'b0;
        m_data_d       = m_data_q;
        m_index_d      = 4'd0;
        m_last_d       = 1'b0;
        s_ready_d      = 1'b0;
        busy_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (beat_accepted) begin
                    // A new job starts with clean error flags.
                    timeout_err_d  = 1'b0;
                    protocol_err_d = 1'b0;
                    state_d        = s_last ? START : LOAD;
                end
            end

            LOAD: begin
                if (beat_accepted && s_last) begin
                    state_d = START;
                end
            end

            START: begin
                // The start code lands on the bus the cycle after the last
                // beat's replay cycle.
                acc_control_d = 4'd0;
                acc_in_bus_d  = '0;
                cnt_d         = 16'd0;
                state_d       = WAIT_DONE;
            end

            WAIT_DONE: begin
                if (acc_done) begin
                    res_buf_d[0] = acc_out_bus;
                    cnt_d        = 16'd0;
                    if (NUM_OUTPUTS == 1) begin
                        idx_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        idx_d   = IDX_W'(1);
                        state_d = CAPTURE;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_err_d = 1'b1;
                    cnt_d         = 16'd0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            CAPTURE: begin
                // The accelerator cannot be stalled, so a word is taken
                // every cycle regardless of the result port.
                res_buf_d[idx_q] = acc_out_bus;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            DRAIN: begin
                if (m_valid_q && m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Replay accepted beats; a zero control code would look like a start
        // command to the accelerator, so it is swallowed and flagged.
        if (beat_accepted) begin
            if (s_control != 4'd0) begin
                acc_control_d = s_control;
                acc_in_bus_d  = s_data;
            end else begin
                protocol_err_d = 1'b1;
            end
        end

        if (acc_done && (state_q != WAIT_DONE)) begin
            protocol_err_d = 1'b1;
        end

        // Result port reflects the word the buffer index will point at.
        if (state_d == DRAIN) begin
            m_valid_d = 1'b1;
            m_data_d  = res_buf_d[idx_d];
            m_index_d = 4'(idx_d);
            m_last_d  = (idx_d == LAST_IDX);
        end

        s_ready_d = (state_d == IDLE) || (state_d == LOAD);
        busy_d    = (state_d != IDLE);
    end

    // Control and status registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            s_ready_q      <= 1'b0;
            acc_control_q  <= IDLE_CTRL;
            acc_in_bus_q   <= '0;
            cnt_q          <= 16'd0;
            idx_q          <= '0;
            m_valid_q      <= 1'b0;
            m_data_q       <= '0;
            m_index_q      <= 4'd0;
            m_last_q       <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            s_ready_q      <= s_ready_d;
            acc_control_q  <= acc_control_d;
            acc_in_bus_q   <= acc_in_bus_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            m_valid_q      <= m_valid_d;
            m_data_q       <= m_data_d;
            m_index_q      <= m_index_d;
            m_last_q       <= m_last_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    // Result buffer holds only data; it is always rewritten before being
    // read in a job, so it carries no reset.
    always_ff @(posedge clk) begin
        res_buf_q <= res_buf_d;
    end

    assign s_ready      = s_ready_q;
    assign acc_control  = acc_control_q;
    assign acc_in_bus   = acc_in_bus_q;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_index      = m_index_q;
    assign m_last       = m_last_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_forward_pass_host.sv
// ---------------------------------------------------------------------------
// tb_forward_pass_host
//
// Directed bench for forward_pass_host with a short timeout (20 cycles).
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, so every check sees the registers written by
// the edge just passed.
// ---------------------------------------------------------------------------
module tb_forward_pass_host;

   logic        clk;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [3:0]  s_control;
   logic [31:0] s_data;
   logic        s_last;
   logic [3:0]  acc_control;
   logic [31:0] acc_in_bus;
   logic        acc_done;
   logic [31:0] acc_out_bus;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic [3:0]  m_index;
   logic        m_last;
   logic        busy;
   logic        timeout_err;
   logic        protocol_err;

   int testsRun;
   int testsFailed;
   int expIdx;
   int stepCount;
   logic sawValid;
   logic readyPattern [4];

   forward_pass_host #(
      .BUS_WIDTH      (32),
      .NUM_OUTPUTS    (10),
      .IDLE_CTRL      (4'hF),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_control    (s_control),
      .s_data       (s_data),
      .s_last       (s_last),
      .acc_control  (acc_control),
      .acc_in_bus   (acc_in_bus),
      .acc_done     (acc_done),
      .acc_out_bus  (acc_out_bus),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_index      (m_index),
      .m_last       (m_last),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .protocol_err (protocol_err)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [3:0] ctrl,
                                input logic [31:0] data, input logic last);
      s_valid   = valid;
      s_control = ctrl;
      s_data    = data;
      s_last    = last;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Three back-to-back beats; returns just after the last one is taken.
   task automatic loadThreeBeats();
      applyStimulus(1'b1, 4'd1, 32'd5, 1'b0);
      tick();
      applyStimulus(1'b1, 4'd2, -32'sd7, 1'b0);
      tick();
      applyStimulus(1'b1, 4'd3, 32'd9, 1'b1);
      tick();
      applyStimulus(1'b0, 4'd0, 32'd0, 1'b0);
   endtask

   // Pulse acc_done with word base, then base+1..base+9 on following cycles.
   task automatic runAccelerator(input int base);
      acc_done    = 1'b1;
      acc_out_bus = 32'(base);
      tick();
      acc_done = 1'b0;
      for (int i = 1; i < 10; i++) begin
         acc_out_bus = 32'(base + i);
         tick();
      end
   endtask

   // Drain all ten words with m_ready held high.
   task automatic drainAll(input int base);
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checkOutput("drain_valid", 32'(m_valid), 32'd1);
         checkOutput("drain_data", m_data, 32'(base + i));
         checkOutput("drain_index", 32'(m_index), 32'(i));
         checkOutput("drain_last", 32'(m_last), (i == 9) ? 32'd1 : 32'd0);
         tick();
      end
      m_ready = 1'b0;
      checkOutput("drain_end_valid", 32'(m_valid), 32'd0);
      checkOutput("drain_end_busy", 32'(busy), 32'd0);
      checkOutput("drain_end_ready", 32'(s_ready), 32'd1);
   endtask

   initial begin
      testsRun        = 0;
      testsFailed     = 0;
      readyPattern[0] = 1'b1;
      readyPattern[1] = 1'b0;
      readyPattern[2] = 1'b0;
      readyPattern[3] = 1'b1;
      rst_n       = 1'b1;
      acc_done    = 1'b0;
      acc_out_bus = 32'd0;
      m_ready     = 1'b0;
      applyStimulus(1'b0, 4'd0, 32'd0, 1'b0);

      // Reset values while reset is held.
      #2 rst_n = 1'b0;
      #6;
      checkOutput("rst_acc_control", 32'(acc_control), 32'hF);
      checkOutput("rst_acc_in_bus", acc_in_bus, 32'd0);
      checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
      checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_m_index", 32'(m_index), 32'd0);
      checkOutput("rst_m_last", 32'(m_last), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
      checkOutput("rst_protocol_err", 32'(protocol_err), 32'd0);
      #14 rst_n = 1'b1;
      tick();
      checkOutput("post_rst_s_ready", 32'(s_ready), 32'd1);

      // Beat replay order, start code, then idle code.
      applyStimulus(1'b1, 4'd1, 32'd5, 1'b0);
      tick();
      checkOutput("beat1_control", 32'(acc_control), 32'd1);
      checkOutput("beat1_data", acc_in_bus, 32'd5);
      checkOutput("beat1_busy", 32'(busy), 32'd1);
      applyStimulus(1'b1, 4'd2, -32'sd7, 1'b0);
      tick();
      checkOutput("beat2_control", 32'(acc_control), 32'd2);
      checkOutput("beat2_data", acc_in_bus, 32'hFFFF_FFF9);
      applyStimulus(1'b1, 4'd3, 32'd9, 1'b1);
      tick();
      checkOutput("beat3_control", 32'(acc_control), 32'd3);
      checkOutput("beat3_data", acc_in_bus, 32'd9);
      checkOutput("beat3_s_ready", 32'(s_ready), 32'd0);
      applyStimulus(1'b0, 4'd0, 32'd0, 1'b0);
      tick();
      checkOutput("start_control", 32'(acc_control), 32'd0);
      checkOutput("start_data", acc_in_bus, 32'd0);
      tick();
      checkOutput("after_start_control", 32'(acc_control), 32'hF);
      checkOutput("wait_m_valid", 32'(m_valid), 32'd0);
      runAccelerator(100);
      drainAll(100);
      checkOutput("job1_protocol_err", 32'(protocol_err), 32'd0);
      checkOutput("job1_timeout_err", 32'(timeout_err), 32'd0);

      // Result drain with m_ready toggling 1,0,0,1.
      loadThreeBeats();
      tick();
      runAccelerator(200);
      expIdx    = 0;
      stepCount = 0;
      while (expIdx < 10 && stepCount < 60) begin
         checkOutput("stall_valid", 32'(m_valid), 32'd1);
         checkOutput("stall_data", m_data, 32'(200 + expIdx));
         checkOutput("stall_index", 32'(m_index), 32'(expIdx));
         checkOutput("stall_last", 32'(m_last), (expIdx == 9) ? 32'd1 : 32'd0);
         m_ready = readyPattern[stepCount % 4];
         tick();
         if (m_ready) expIdx++;
         stepCount++;
      end
      m_ready = 1'b0;
      checkOutput("stall_words_drained", 32'(expIdx), 32'd10);
      checkOutput("stall_end_valid", 32'(m_valid), 32'd0);
      checkOutput("stall_end_busy", 32'(busy), 32'd0);

      // Timeout after exactly 20 cycles in WAIT_DONE.
      loadThreeBeats();
      tick();
      sawValid = 1'b0;
      for (int i = 0; i < 19; i++) begin
         tick();
         if (m_valid) sawValid = 1'b1;
      end
      checkOutput("timeout_cycle19_err", 32'(timeout_err), 32'd0);
      checkOutput("timeout_cycle19_busy", 32'(busy), 32'd1);
      tick();
      checkOutput("timeout_err_set", 32'(timeout_err), 32'd1);
      checkOutput("timeout_busy", 32'(busy), 32'd0);
      checkOutput("timeout_s_ready", 32'(s_ready), 32'd1);
      checkOutput("timeout_m_valid", 32'(m_valid | sawValid), 32'd0);

      // Next job clears the flag; a zero control beat is swallowed.
      applyStimulus(1'b1, 4'd1, 32'd1, 1'b0);
      tick();
      checkOutput("timeout_err_cleared", 32'(timeout_err), 32'd0);
      checkOutput("job4_busy", 32'(busy), 32'd1);
      applyStimulus(1'b1, 4'd0, 32'd77, 1'b0);
      tick();
      checkOutput("zero_ctrl_control", 32'(acc_control), 32'hF);
      checkOutput("zero_ctrl_data", acc_in_bus, 32'd0);
      checkOutput("zero_ctrl_protocol_err", 32'(protocol_err), 32'd1);
      checkOutput("zero_ctrl_s_ready", 32'(s_ready), 32'd1);
      applyStimulus(1'b1, 4'd4, 32'd11, 1'b1);
      tick();
      checkOutput("job4_last_control", 32'(acc_control), 32'd4);
      checkOutput("job4_last_data", acc_in_bus, 32'd11);
      applyStimulus(1'b0, 4'd0, 32'd0, 1'b0);
      tick();
      checkOutput("job4_start_control", 32'(acc_control), 32'd0);
      runAccelerator(300);
      drainAll(300);
      checkOutput("protocol_err_sticky", 32'(protocol_err), 32'd1);

      // Reset in the middle of CAPTURE, then a full job.
      loadThreeBeats();
      checkOutput("job5_protocol_err_cleared", 32'(protocol_err), 32'd0);
      tick();
      acc_done    = 1'b1;
      acc_out_bus = 32'd400;
      tick();
      acc_done    = 1'b0;
      acc_out_bus = 32'd401;
      tick();
      checkOutput("capture_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_s_ready", 32'(s_ready), 32'd0);
      checkOutput("midrst_acc_control", 32'(acc_control), 32'hF);
      checkOutput("midrst_m_valid", 32'(m_valid), 32'd0);
      checkOutput("midrst_m_index", 32'(m_index), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      checkOutput("after_rst_s_ready", 32'(s_ready), 32'd1);
      checkOutput("after_rst_busy", 32'(busy), 32'd0);
      loadThreeBeats();
      tick();
      runAccelerator(500);
      drainAll(500);

      // acc_done while idle is ignored but flagged.
      acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
      checkOutput("stray_done_protocol_err", 32'(protocol_err), 32'd1);
      checkOutput("stray_done_busy", 32'(busy), 32'd0);
      checkOutput("stray_done_m_valid", 32'(m_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
